// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, trap cause codes, funct3 encodings and decode helpers for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {C_NONE, C_MISALIGN, C_TIMEOUT, C_ILLEGAL} cause_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  function automatic logic f3_legal(input logic we, input logic [2:0] f3, input logic rv64);
    return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W || (rv64 && f3 == F3_D))
              : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU ||
                 (rv64 && (f3 == F3_D || f3 == F3_WU)));
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a);
    return f3[1:0] == 2'd1 ? a[0] : f3[1:0] == 2'd2 ? |a[1:0] : f3[1:0] == 2'd3 ? |a : 1'b0;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane mask, store data lane shift and load extract/extend
module lsu_align #(
  parameter int XLEN = 32
) (
  input  logic [2:0]                  funct3,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  logic [XLEN-1:0]             wdata,
  input  logic [XLEN-1:0]             rdata,
  output logic [XLEN/8-1:0]           mask,
  output logic [XLEN-1:0]             wdata_sh,
  output logic [XLEN-1:0]             rdata_ext
);
  localparam int NB = XLEN / 8;
  logic [7:0] base;
  logic [5:0] sb;
  logic [63:0] wm, sh;
  logic [XLEN-1:0] rd_sh;
  always_comb begin
    base = funct3[1:0] == 2'd0 ? 8'h01 : funct3[1:0] == 2'd1 ? 8'h03 : funct3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
    mask = NB'(base) << off;
    wdata_sh = wdata << {off, 3'b000};
    rd_sh = rdata >> {off, 3'b000};
    sh = 64'(rd_sh);
    wm = funct3[1:0] == 2'd0 ? 64'hFF : funct3[1:0] == 2'd1 ? 64'hFFFF :
         funct3[1:0] == 2'd2 ? 64'hFFFF_FFFF : '1;
    sb = funct3[1:0] == 2'd0 ? 6'd7 : funct3[1:0] == 2'd1 ? 6'd15 : funct3[1:0] == 2'd2 ? 6'd31 : 6'd63;
    // funct3[2] selects zero-extension; otherwise replicate the lane's top bit
    rdata_ext = XLEN'((sh & wm) | ((~funct3[2] & sh[sb]) ? ~wm : 64'd0));
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller with alignment/funct3 traps and a bus timeout
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_rsp_valid,
  output logic [XLEN-1:0]   o_rsp_rdata,
  output logic              o_rsp_trap,
  output logic [1:0]        o_rsp_cause,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [31:0]       o_mem_addr,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_mask,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic we_q, we_d, req_ready_q, req_ready_d, mem_valid_q, mem_valid_d;
  logic rsp_valid_q, rsp_valid_d, rsp_trap_q, rsp_trap_d;
  logic [1:0] rsp_cause_q, rsp_cause_d;
  logic [2:0] f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d, wdata_sh, rdata_ext;
  logic [NB-1:0] mask;
  logic tmo;
  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3(f3_q), .off(addr_q[OW-1:0]), .wdata(wdata_q), .rdata(i_mem_rdata),
    .mask(mask), .wdata_sh(wdata_sh), .rdata_ext(rdata_ext)
  );
  assign tmo = cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    f3_d = f3_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    req_ready_d = 1'b0;
    mem_valid_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_trap_d = 1'b0;
    rsp_cause_d = C_NONE;
    rsp_rdata_d = '0;
    case (state_q)
      S_IDLE: begin
        req_ready_d = ~i_req_valid;
        if (i_req_valid) begin
          we_d = i_req_we;
          f3_d = i_req_funct3;
          addr_d = i_req_addr;
          wdata_d = i_req_wdata;
          if (!f3_legal(i_req_we, i_req_funct3, XLEN == 64)) begin
            state_d = S_RESP;
            {rsp_valid_d, rsp_trap_d, rsp_cause_d} = {2'b11, C_ILLEGAL};
          end else if (misaligned(i_req_funct3, i_req_addr[2:0])) begin
            state_d = S_RESP;
            {rsp_valid_d, rsp_trap_d, rsp_cause_d} = {2'b11, C_MISALIGN};
          end else begin
            state_d = S_REQ;
            mem_valid_d = 1'b1;
            cnt_d = '0;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (i_mem_ready) begin
          state_d = we_q ? S_RESP : S_WAIT;
          rsp_valid_d = we_q;
        end else if (tmo) begin
          state_d = S_RESP;
          {rsp_valid_d, rsp_trap_d, rsp_cause_d} = {2'b11, C_TIMEOUT};
        end else mem_valid_d = 1'b1;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (i_mem_rvalid) begin
          state_d = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata_ext;
        end else if (tmo) begin
          state_d = S_RESP;
          {rsp_valid_d, rsp_trap_d, rsp_cause_d} = {2'b11, C_TIMEOUT};
        end
      end
      default: begin
        state_d = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      req_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_trap_q <= 1'b0;
      rsp_cause_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      f3_q <= f3_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      req_ready_q <= req_ready_d;
      mem_valid_q <= mem_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_trap_q <= rsp_trap_d;
      rsp_cause_q <= rsp_cause_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  // Bus fields are gated so an idle bus reads as all zeros
  assign o_req_ready = req_ready_q;
  assign o_mem_valid = mem_valid_q;
  assign o_mem_addr  = mem_valid_q ? {addr_q[31:OW], {OW{1'b0}}} : '0;
  assign o_mem_ren   = mem_valid_q & ~we_q;
  assign o_mem_wen   = mem_valid_q & we_q;
  assign o_mem_wdata = (mem_valid_q & we_q) ? wdata_sh : '0;
  assign o_mem_mask  = mem_valid_q ? mask : '0;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_trap  = rsp_trap_q;
  assign o_rsp_cause = rsp_cause_q;
  assign o_rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven and hand-sequenced checks of lsu_ctrl (XLEN=32/TIMEOUT=4 and XLEN=64)
module tb_lsu_ctrl;
  typedef struct {
    logic d64; logic we; logic [2:0] f3; logic [31:0] addr;
    logic [63:0] wdata, rdata; logic [31:0] maddr; logic [7:0] mask;
    logic [63:0] mwdata, exp_rdata; logic [1:0] cause; int lat;
  } vec_t;
  typedef struct { logic [63:0] rdata; logic [1:0] cause; int cyc; } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;

  logic rv32 = 0, rv64 = 0, we = 0, mem_ready = 0, mem_rvalid = 0;
  logic [2:0] f3 = '0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0, mrdata = '0;

  logic rdy32, rspv32, trap32, mv32, ren32, wen32, rdy64, rspv64, trap64, mv64, ren64, wen64;
  logic [1:0] cause32, cause64;
  logic [31:0] rd32, ma32, wd32, ma64;
  logic [3:0] mask32;
  logic [7:0] mask64;
  logic [63:0] rd64, wd64;

  lsu_ctrl #(.XLEN(32), .TIMEOUT(4)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(rv32), .o_req_ready(rdy32), .i_req_we(we),
    .i_req_funct3(f3), .i_req_addr(addr), .i_req_wdata(wdata[31:0]), .o_rsp_valid(rspv32),
    .o_rsp_rdata(rd32), .o_rsp_trap(trap32), .o_rsp_cause(cause32), .o_mem_valid(mv32),
    .i_mem_ready(mem_ready), .o_mem_addr(ma32), .o_mem_ren(ren32), .o_mem_wen(wen32),
    .o_mem_wdata(wd32), .o_mem_mask(mask32), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mrdata[31:0])
  );
  lsu_ctrl #(.XLEN(64), .TIMEOUT(8)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(rv64), .o_req_ready(rdy64), .i_req_we(we),
    .i_req_funct3(f3), .i_req_addr(addr), .i_req_wdata(wdata), .o_rsp_valid(rspv64),
    .o_rsp_rdata(rd64), .o_rsp_trap(trap64), .o_rsp_cause(cause64), .o_mem_valid(mv64),
    .i_mem_ready(mem_ready), .o_mem_addr(ma64), .o_mem_ren(ren64), .o_mem_wen(wen64),
    .o_mem_wdata(wd64), .o_mem_mask(mask64), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mrdata)
  );

  exp_t q32[$], q64[$];
  exp_t e32, e64;
  vec_t vt[22];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic d, input logic w, input logic [2:0] f, input logic [31:0] a, input logic [63:0] wd);
    we = w; f3 = f; addr = a; wdata = wd;
    if (d) rv64 = 1'b1; else rv32 = 1'b1;
    tick();
    rv32 = 1'b0; rv64 = 1'b0;
  endtask

  // Response scoreboard: every pulse must match the oldest expectation, including its cycle
  always @(negedge clk) begin
    if (rspv32) begin
      if (q32.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rsp32_unexpected: got pulse cause %0d expected none", cause32);
      end else begin
        e32 = q32.pop_front();
        chk("rsp32_rdata", 64'(rd32), e32.rdata);
        chk("rsp32_trap", 64'(trap32), 64'(e32.cause != 0));
        chk("rsp32_cause", 64'(cause32), 64'(e32.cause));
        chk("rsp32_cycle", 64'(cyc), 64'(e32.cyc));
      end
    end else chk("rsp32_quiet", {rd32, trap32, cause32}, 0);
    if (rspv64) begin
      if (q64.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rsp64_unexpected: got pulse cause %0d expected none", cause64);
      end else begin
        e64 = q64.pop_front();
        chk("rsp64_rdata", rd64, e64.rdata);
        chk("rsp64_trap", 64'(trap64), 64'(e64.cause != 0));
        chk("rsp64_cause", 64'(cause64), 64'(e64.cause));
        chk("rsp64_cycle", 64'(cyc), 64'(e64.cyc));
      end
    end else chk("rsp64_quiet", {rd64[61:0], trap64, cause64}, 0);
    if (mv32 || mv64) chk("mem_rw_excl", {ren32 & wen32, ren64 & wen64}, 0);
  end

  task automatic run_vec(input vec_t v);
    int n = 0;
    exp_t e;
    while (!(v.d64 ? rdy64 : rdy32) && n < 20) begin tick(); n++; end
    chk("req_ready", 64'(v.d64 ? rdy64 : rdy32), 1);
    e = '{v.exp_rdata, v.cause, cyc + v.lat};
    if (v.d64) q64.push_back(e); else q32.push_back(e);
    drive(v.d64, v.we, v.f3, v.addr, v.wdata);
    chk("req_busy", 64'(v.d64 ? rdy64 : rdy32), 0);
    if (v.cause != 0) chk("trap_no_mem", 64'(v.d64 ? mv64 : mv32), 0);
    else begin
      chk("mem_valid", 64'(v.d64 ? mv64 : mv32), 1);
      chk("mem_addr", 64'(v.d64 ? ma64 : ma32), 64'(v.maddr));
      chk("mem_mask", 64'(v.d64 ? mask64 : 8'(mask32)), 64'(v.mask));
      chk("mem_wdata", v.d64 ? wd64 : 64'(wd32), v.mwdata);
      chk("mem_ren_wen", 64'(v.d64 ? {ren64, wen64} : {ren32, wen32}), 64'({~v.we, v.we}));
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      if (!v.we) begin
        mrdata = v.rdata; mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
      end
    end
    tick(); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt = '{
      '{0, 1, 3'd0, 32'h2003, 64'hAB, 64'h0, 32'h2000, 8'h08, 64'hAB00_0000, 64'h0, 2'd0, 2},
      '{0, 0, 3'd1, 32'h1002, 64'h0, 64'h8001_1234, 32'h1000, 8'h0C, 64'h0, 64'hFFFF_8001, 2'd0, 3},
      '{0, 0, 3'd5, 32'h1002, 64'h0, 64'h8001_1234, 32'h1000, 8'h0C, 64'h0, 64'h0000_8001, 2'd0, 3},
      '{0, 0, 3'd2, 32'h1001, 64'h0, 64'h0, 32'h0, 8'h0, 64'h0, 64'h0, 2'd1, 1},
      '{0, 0, 3'd3, 32'h1000, 64'h0, 64'h0, 32'h0, 8'h0, 64'h0, 64'h0, 2'd3, 1},
      '{0, 0, 3'd3, 32'h1001, 64'h0, 64'h0, 32'h0, 8'h0, 64'h0, 64'h0, 2'd3, 1},
      '{0, 0, 3'd0, 32'h1001, 64'h0, 64'h0000_8000, 32'h1000, 8'h02, 64'h0, 64'hFFFF_FF80, 2'd0, 3},
      '{0, 0, 3'd4, 32'h1003, 64'h0, 64'hF000_0000, 32'h1000, 8'h08, 64'h0, 64'h0000_00F0, 2'd0, 3},
      '{0, 1, 3'd2, 32'h3000, 64'hDEAD_BEEF, 64'h0, 32'h3000, 8'h0F, 64'hDEAD_BEEF, 64'h0, 2'd0, 2},
      '{0, 1, 3'd1, 32'h3002, 64'h1234, 64'h0, 32'h3000, 8'h0C, 64'h1234_0000, 64'h0, 2'd0, 2},
      '{0, 1, 3'd1, 32'h3001, 64'h1234, 64'h0, 32'h0, 8'h0, 64'h0, 64'h0, 2'd1, 1},
      '{0, 1, 3'd4, 32'h3000, 64'h1, 64'h0, 32'h0, 8'h0, 64'h0, 64'h0, 2'd3, 1},
      '{0, 0, 3'd2, 32'h4000, 64'h0, 64'h8765_4321, 32'h4000, 8'h0F, 64'h0, 64'h8765_4321, 2'd0, 3},
      '{0, 1, 3'd3, 32'h3000, 64'h1, 64'h0, 32'h0, 8'h0, 64'h0, 64'h0, 2'd3, 1},
      '{0, 0, 3'd6, 32'h4000, 64'h0, 64'h0, 32'h0, 8'h0, 64'h0, 64'h0, 2'd3, 1},
      '{1, 0, 3'd3, 32'h10, 64'h0, 64'h1122_3344_5566_7788, 32'h10, 8'hFF, 64'h0, 64'h1122_3344_5566_7788, 2'd0, 3},
      '{1, 0, 3'd6, 32'h14, 64'h0, 64'h8000_0000_0000_0000, 32'h10, 8'hF0, 64'h0, 64'h0000_0000_8000_0000, 2'd0, 3},
      '{1, 0, 3'd2, 32'h14, 64'h0, 64'h8000_0000_0000_0000, 32'h10, 8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0000, 2'd0, 3},
      '{1, 1, 3'd3, 32'h18, 64'hA5A5_0123_4567_89AB, 64'h0, 32'h18, 8'hFF, 64'hA5A5_0123_4567_89AB, 64'h0, 2'd0, 2},
      '{1, 1, 3'd0, 32'h17, 64'h5A, 64'h0, 32'h10, 8'h80, 64'h5A00_0000_0000_0000, 64'h0, 2'd0, 2},
      '{1, 0, 3'd3, 32'h14, 64'h0, 64'h0, 32'h0, 8'h0, 64'h0, 64'h0, 2'd1, 1},
      '{1, 1, 3'd6, 32'h10, 64'h1, 64'h0, 32'h0, 8'h0, 64'h0, 64'h0, 2'd3, 1}
    };
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready32", 64'(rdy32), 1);
    chk("rst_ready64", 64'(rdy64), 1);
    chk("rst_mem32", {mv32, ren32, wen32, mask32, ma32, wd32}, 0);
    chk("rst_mem64", {mv64, ren64, wen64, mask64, ma64[23:0]}, 0);
    chk("rst_rsp32", {rspv32, trap32, cause32, rd32}, 0);
    rst = 1'b0;
    tick();
    foreach (vt[i]) run_vec(vt[i]);

    // Store with ready withheld two cycles: request fields must stay stable
    q32.push_back('{64'h0, 2'd0, cyc + 4});
    drive(0, 1, 3'd2, 32'h3004, 64'h0102_0304);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 64'(mv32), 1);
      chk("hold_addr", 64'(ma32), 64'h3004);
      chk("hold_wdata", 64'(wd32), 64'h0102_0304);
      chk("hold_mask", 64'(mask32), 64'hF);
      if (i == 2) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    repeat (3) tick();

    // Timeout in REQ with ready never asserted
    q32.push_back('{64'h0, 2'd2, cyc + 5});
    drive(0, 0, 3'd2, 32'h5000, 64'h0);
    chk("to_valid", 64'(mv32), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_valid", 64'(mv32), 1);
    end
    tick();
    chk("to_drop", 64'(mv32), 0);
    repeat (3) tick();

    // Timeout in WAIT: handshake done, read data never returned
    q32.push_back('{64'h0, 2'd2, cyc + 5});
    drive(0, 0, 3'd2, 32'h5004, 64'h0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("wait_no_valid", 64'(mv32), 0);
    repeat (5) tick();

    // Reset during WAIT, then a stray rvalid: no response may appear
    drive(0, 0, 3'd2, 32'h6000, 64'h0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(rdy32), 1);
    chk("mid_rst_quiet", {mv32, rspv32, ren32}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mrdata = 64'h1357_9BDF; mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk("post_rst_ready", 64'(rdy32), 1);
    repeat (2) tick();

    chk("q32_drained", 64'(q32.size()), 0);
    chk("q64_drained", 64'(q64.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/memory bus width; legal values 32 or 64.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning max cycles in REQ+WAIT before a timeout trap; must be >= 1.
REQ-003 SHALL have port i_clk  in  1  global clock, rising edge.
REQ-004 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_req_valid  in  1  hart access request.
REQ-006 SHALL have port o_req_ready  out  1  unit can accept a request.
REQ-007 SHALL have port i_req_we  in  1  1=store, 0=load.
REQ-008 SHALL have port i_req_funct3  in  3  RISC-V load/store funct3.
REQ-009 SHALL have port i_req_addr  in  32  byte address.
REQ-010 SHALL have port i_req_wdata  in  XLEN  store data, LSB-aligned.
REQ-011 SHALL have port o_rsp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port o_rsp_rdata  out  XLEN  extended load result; 0 for stores and traps.
REQ-013 SHALL have port o_rsp_trap  out  1  access trapped.
REQ-014 SHALL have port o_rsp_cause  out  2  cause code: 0 none, 1 misaligned, 2 timeout, 3 illegal funct3.
REQ-015 SHALL have port o_mem_valid  out  1  memory request valid.
REQ-016 SHALL have port i_mem_ready  in  1  memory accepts request.
REQ-017 SHALL have port o_mem_addr  out  32  address aligned to XLEN/8 bytes.
REQ-018 SHALL have port o_mem_ren / o_mem_wen  out  1 each  read or write; never both asserted.
REQ-019 SHALL have port o_mem_wdata  out  XLEN  lane-shifted store data.
REQ-020 SHALL have port o_mem_mask  out  XLEN/8  byte-lane enables.
REQ-021 SHALL have port i_mem_rvalid  in  1  read data valid.
REQ-022 SHALL have port i_mem_rdata  in  XLEN  raw read word.

Function
REQ-023 SHALL implement FSM IDLE, REQ, WAIT, RESP; o_req_ready=1 only in IDLE.
REQ-024 In IDLE with i_req_valid: latch we/funct3/addr/wdata; go to RESP with trap if illegal or misaligned, else to REQ.
REQ-025 Legal funct3: loads 000,001,010,100,101, plus 011,110 when XLEN=64; stores 000,001,010, plus 011 when XLEN=64; others give cause 3.
REQ-026 Alignment: half needs addr[0]=0, word addr[1:0]=0, double addr[2:0]=0; violation gives cause 1 and issues no memory request; cause 3 takes priority over cause 1.
REQ-027 REQ: o_mem_valid=1 with latched fields held stable until i_mem_ready; store goes to RESP on ready; load goes to WAIT on ready.
REQ-028 WAIT: on i_mem_rvalid capture lane-extracted, sign/zero-extended data (funct3[2]=1 means zero-extend), then go to RESP; i_mem_rvalid in any other state is ignored.
REQ-029 Mask = (1/3/0xF/0xFF for byte/half/word/double) << addr offset; wdata is shifted left by 8*offset.
REQ-030 Timeout counter clears on entering REQ and counts each REQ/WAIT cycle; when the count reaches TIMEOUT, drop o_mem_valid and go to RESP with cause 2.
REQ-031 RESP: o_rsp_valid=1 for exactly one cycle, then IDLE; a new request is not accepted in RESP.
REQ-032 Latency from accept edge: aligned store with ready=1 gives rsp 2 cycles later; load with ready, then rvalid next cycle, gives rsp 3 cycles later; a trapped request gives rsp 1 cycle later.
REQ-033 o_rsp_rdata, o_rsp_trap and o_rsp_cause SHALL be 0 whenever o_rsp_valid=0.

Reset
REQ-034 i_rst SHALL asynchronously force IDLE, counter 0, all latched fields 0, and all outputs 0 except o_req_ready=1.
REQ-035 Reset mid-REQ/WAIT abandons the access without producing an rsp pulse; a later stray i_mem_rvalid is ignored.

Structure
REQ-036 Package lsu_pkg SHALL hold the state enum, cause codes and funct3 constants.
REQ-037 Combinational sub-module lsu_align SHALL compute the mask, wdata shift and read extract/extend.
REQ-038 Counter width SHALL be $clog2(TIMEOUT+1).

Verification
REQ-039 XLEN=32, sb addr 0x2003 data 0xAB -> mask 1000, addr 0x2000, wdata 0xAB000000, rsp 2 cycles later, no trap.
REQ-040 lh addr 0x1002, rdata 0x8001_1234 -> o_rsp_rdata 0xFFFF8001; lhu -> 0x00008001.
REQ-041 lw addr 0x1001 -> cause 1, o_mem_valid never asserted, rsp 1 cycle later.
REQ-042 XLEN=32, funct3 011 load -> cause 3; XLEN=64, ld addr 0x10 -> mask 0xFF, full 64-bit data returned.
REQ-043 TIMEOUT=4, i_mem_ready held 0 -> cause 2 on the 5th cycle after accept, o_mem_valid dropped.
REQ-044 Assert i_rst during WAIT, then drive rvalid -> no rsp pulse, o_req_ready=1 immediately.
